// File: rtl/uart_pkg.sv
// Shared constants, state encoding and checksum helper for the framed UART transmitter.
package uart_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    return a ^ b ^ c;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer: start, 8 data bits LSB first, optional even parity, stop.
// UART_PARITY_EN selects 8E1; otherwise 8N1.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int NUM_CYCLES_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_out,
  output logic       done
);
  localparam int            CW       = $clog2(NUM_CYCLES_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(NUM_CYCLES_PER_BIT - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, load, shift, tx_nxt;
`ifdef UART_PARITY_EN
  logic          par;
`endif

  assign tick = (bit_cnt == BIT_LAST);

  // tx_nxt is the line value for the next cycle, so the line is always a flop.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_out;
    load      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = START;
        tx_nxt    = 1'b0;
      end
      START: if (tick) begin
        state_nxt = DATA;
        tx_nxt    = shreg[0];
      end
      DATA: if (tick) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_nxt = PARITY;
          tx_nxt    = par;
`else
          state_nxt = STOP;
          tx_nxt    = 1'b1;
`endif
        end else begin
          shift  = 1'b1;
          tx_nxt = shreg[1];
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
`endif
      STOP: if (tick) begin
        done = 1'b1;
        // a start here chains the next byte with no idle gap
        if (start) begin
          load      = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_out  <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      tx_out <= tx_nxt;
      if (state == IDLE || tick) bit_cnt <= '0;
      else                       bit_cnt <= bit_cnt + CW'(1);
      if (load) begin
        shreg   <= data;
        bit_idx <= '0;
`ifdef UART_PARITY_EN
        par     <= ^data;
`endif
      end else if (shift) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end
endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: SYNC, cmd, payload, checksum per accepted request.
// UART_PARITY_EN selects 8E1 bytes (11 bits); otherwise 8N1 (10 bits).
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int NUM_CYCLES_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  output logic       frame_ready,
  input  logic [7:0] cmd,
  input  logic [7:0] payload,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);
  logic       accept, byte_start, byte_done, last_byte;
  logic [7:0] byte_data, cmd_q, payload_q, csum_q;
  logic [1:0] byte_idx;

  assign frame_ready = ~busy;
  assign accept      = frame_valid & frame_ready;
  assign last_byte   = (byte_idx == 2'(FRAME_LEN - 1));
  assign byte_start  = accept | (byte_done & ~last_byte);

  // byte_idx names the byte on the line; on its done we feed the one after it
  always_comb begin
    byte_data = SYNC_BYTE;
    if (!accept) begin
      case (byte_idx)
        2'd0:    byte_data = cmd_q;
        2'd1:    byte_data = payload_q;
        default: byte_data = csum_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_idx   <= '0;
      cmd_q      <= '0;
      payload_q  <= '0;
      csum_q     <= '0;
    end else begin
      frame_done <= byte_done & last_byte;
      if (accept) begin
        busy      <= 1'b1;
        byte_idx  <= '0;
        cmd_q     <= cmd;
        payload_q <= payload;
        csum_q    <= checksum(SYNC_BYTE, cmd, payload);
      end else if (byte_done) begin
        if (last_byte) begin
          busy     <= 1'b0;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

  uart_tx_byte #(.NUM_CYCLES_PER_BIT(NUM_CYCLES_PER_BIT)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (byte_start),
    .data   (byte_data),
    .tx_out (tx_out),
    .done   (byte_done)
  );
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

- Framed UART transmitter that sends one 4-byte command frame per request: SYNC, CMD, PAYLOAD, CHECKSUM.
- It is the sending end of the motor-command link. A board-side or loopback-test controller uses it to drive commands into the receiver/motor path.
- It shares the receiver's bit timing and parity convention, so a frame sent here is accepted by the receive side unchanged.

## Interface
- NUM_CYCLES_PER_BIT, default 10417: clock cycles per UART bit. Must be ≥ 2.
- clk  input  1  system clock (the 16 MHz wizard clock).
- rst  input  1  asynchronous, active-low reset.
- frame_valid  input  1  request to send a frame. Qualified by frame_ready.
- frame_ready  output  1  block can accept a frame this cycle.
- cmd  input  8  command byte, sampled on accept.
- payload  input  8  payload byte, sampled on accept.
- tx_out  output  1  serial line. Idle high.
- busy  output  1  frame in flight.
- frame_done  output  1  one-cycle pulse after the last stop bit of byte 3.

## Operation
- Frame bytes are sent in index order:
  - 0: SYNC = 0xA5
  - 1: cmd
  - 2: payload
  - 3: checksum = 0xA5 ^ cmd ^ payload
- Byte format: 1 start bit (0), 8 data bits LSB first, optional even-parity bit, 1 stop bit (1).
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after one bit time.
  - DATA → PARITY after 8 bits (parity enabled), or DATA → STOP (parity disabled).
  - PARITY → STOP after one bit time.
  - STOP → START when byte index < 3. Byte index increments; no inter-byte gap.
  - STOP → IDLE when byte index = 3. frame_done pulses.
- Accept occurs when frame_valid && frame_ready. cmd, payload and the computed checksum are latched on that clock edge.
- frame_ready = 1 only in IDLE. frame_valid while busy is ignored; no queuing.
- Bit counter: 0..NUM_CYCLES_PER_BIT-1, wraps at terminal count and advances the state. Data bit index is 0..7. Byte index is 0..3, 2 bits wide, no wrap past 3.
- Parity bit = XOR of the 8 data bits (even parity).
- Reset values: tx_out=1, busy=0, frame_ready=1 (once rst is high), frame_done=0, state IDLE, all counters 0.

## Timing
- Accept at edge E: tx_out=0 (start bit) and busy=1 from the cycle after E.
- Each bit holds tx_out stable for exactly NUM_CYCLES_PER_BIT cycles.
- Frame duration from first start-bit cycle to the end of the last stop bit: 4·B·NUM_CYCLES_PER_BIT cycles, where B = 11 with parity and B = 10 without.
- Return to IDLE:
  - In the cycle after the last stop bit completes: frame_done=1, busy=0, frame_ready=1, tx_out=1.
  - An accept in that same cycle starts the next frame with a one-cycle idle-high gap.
- frame_done and an accept in the same cycle are legal and both take effect.
- Reset mid-frame:
  - tx_out=1 asynchronously; the frame is discarded and frame_done is not pulsed.
  - After release, the block is in IDLE with frame_ready=1.
- tx_out is driven from a flop, so there are no combinational glitches on the line.

## Configuration
- Macro UART_PARITY_EN.
- Defined: PARITY state present, 11 bits per byte (8E1), matching a receiver that checks parity.
- Undefined: PARITY state and parity logic removed, 10 bits per byte (8N1).

## Structure
- Package uart_pkg holds:
  - SYNC_BYTE = 8'hA5
  - FRAME_LEN = 4
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - a checksum function: XOR of three bytes
- One natural sub-module, uart_tx_byte: a single-byte serializer with the bit-time counter and parity, and a start/done handshake.
- uart_frame_tx owns byte sequencing, latching, checksum and frame_ready/frame_done.

## Test plan
All scenarios use NUM_CYCLES_PER_BIT=4.
- Reset release, no requests → tx_out=1, frame_ready=1, busy=0 held for 100 cycles.
- cmd=0x01, payload=0x64, UART_PARITY_EN defined:
  - line decodes to bytes A5 01 64 C0 with parity bits 0,1,1,0
  - frame_done pulses once, 176 cycles after the first start bit
- Same frame with the macro undefined → same bytes, no parity bits, frame_done after 160 cycles.
- Second frame_valid pulsed mid-frame (cmd=0xFF) → ignored; the line carries only the first frame, and frame_ready stays 0 until frame_done.
- frame_valid held high continuously with cmd=0x02, payload=0x10 → frames repeat with exactly one idle-high cycle between the final stop bit and the next start bit; checksum 0xB7.
- rst asserted during the DATA bits of byte 2 → tx_out=1 immediately, no frame_done; a fresh frame after release is transmitted correctly from SYNC.
